gem_pattern_sequencer: RTL and testbench

Replays stored GEM cluster frames from a pattern RAM into the 56-bit `gemdata` path that feeds the GEM cluster decoder and the OTMB link. Each frame is one bx: four 14-bit cluster words, each `{cnt[2:0], adr[10:0]}`. The block sequences RAM reads over a programmed address window, loops it a programmed number of times, optionally aligns the start to bx0, and emits idle frames whenever it is not playing. It also keeps saturating frame and valid-cluster counters for run monitoring.

---
 rtl/gem_pkg.sv | 23 ++
 rtl/gem_vpf_count.sv | 19 +
 rtl/gem_pattern_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_gem_pattern_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_pkg.sv
// rtl/gem_pkg.sv - shared GEM cluster constants, sequencer state enum, cluster valid helper
package gem_pkg;

  localparam int MXCLST   = 4;
  localparam int CLSTBITS = 14;

  // cnt=0, adr[10:9]=2'b11: never a real cluster, so it marks "no cluster"
  localparam logic [CLSTBITS-1:0] IDLE_CLUSTER = 14'h07FF;
  localparam logic [MXCLST*CLSTBITS-1:0] IDLE_FRAME = {MXCLST{IDLE_CLUSTER}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // A cluster word {cnt[2:0], adr[10:0]} is valid unless adr[10:9] == 2'b11
  function automatic logic cluster_vpf(input logic [CLSTBITS-1:0] word);
    return word[10:9] != 2'b11;
  endfunction

endpackage

// File: rtl/gem_vpf_count.sv
// rtl/gem_vpf_count.sv - combinational count of valid clusters in one GEM frame
// Ports:
//   frame   in  MXCLST*CLSTBITS  one bx worth of cluster words
//   vpf_cnt out 3                number of valid clusters (0..4)
module gem_vpf_count
  import gem_pkg::*;
(
  input  logic [MXCLST*CLSTBITS-1:0] frame,
  output logic [2:0]                 vpf_cnt
);

  always_comb begin
    vpf_cnt = 3'd0;
    for (int i = 0; i < MXCLST; i++) begin
      vpf_cnt = vpf_cnt + 3'(cluster_vpf(frame[i*CLSTBITS +: CLSTBITS]));
    end
  end

endmodule

// File: rtl/gem_pattern_sequencer.sv
// rtl/gem_pattern_sequencer.sv - replays pattern RAM frames onto the GEM data path
// Ports:
//   clock, global_reset_n         40 MHz clock, async active-low reset
//   start, stop, sync_bx0, bx0    playback control
//   first_adr, last_adr, n_loops  replay window and repetition count (0 = endless)
//   ram_rd_en, ram_adr, ram_rdata pattern RAM read port, 1-cycle read latency
//   gemdata, gemdata_valid        frame output, idle frame when not playing
//   busy, done, cfg_err           status
//   loop_cnt, frame_cnt, clst_cnt run monitoring counters
module gem_pattern_sequencer #(
  parameter int RAM_ADRB = 11,
  parameter int MXCLST   = 4,
  parameter int CLSTBITS = 14
) (
  input  logic                         clock,
  input  logic                         global_reset_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         sync_bx0,
  input  logic                         bx0,
  input  logic [RAM_ADRB-1:0]          first_adr,
  input  logic [RAM_ADRB-1:0]          last_adr,
  input  logic [7:0]                   n_loops,
  output logic                         ram_rd_en,
  output logic [RAM_ADRB-1:0]          ram_adr,
  input  logic [MXCLST*CLSTBITS-1:0]   ram_rdata,
  output logic [MXCLST*CLSTBITS-1:0]   gemdata,
  output logic                         gemdata_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic [7:0]                   loop_cnt,
  output logic [31:0]                  frame_cnt,
  output logic [31:0]                  clst_cnt
);

  import gem_pkg::*;

  localparam int FW = MXCLST * CLSTBITS;

  state_e                state_q, state_d;
  logic                  drain_q, drain_d;
  logic [RAM_ADRB-1:0]   first_q, first_d, last_q, last_d;
  logic [RAM_ADRB-1:0]   ram_adr_q, ram_adr_d;
  logic [7:0]            n_loops_q, n_loops_d, loop_cnt_q, loop_cnt_d;
  logic                  ram_rd_en_q, ram_rd_en_d;
  logic                  rdata_vld_q, rdata_vld_d;
  logic                  gemdata_valid_q, gemdata_valid_d;
  logic [FW-1:0]         gemdata_q, gemdata_d;
  logic                  busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [31:0]           frame_cnt_q, frame_cnt_d, clst_cnt_q, clst_cnt_d;
  logic [2:0]            vpf_cnt;
  logic [32:0]           clst_sum;
  logic                  kill, start_ok, at_last, last_pass;

  gem_vpf_count u_vpf_count (
    .frame   (ram_rdata),
    .vpf_cnt (vpf_cnt)
  );

  // stop only has an effect while playing; in IDLE it just blocks a start
  assign kill      = stop && (state_q != ST_IDLE);
  assign start_ok  = start && !stop && (first_adr <= last_adr);
  assign at_last   = (ram_adr_q == last_q);
  assign last_pass = (n_loops_q != 8'd0) && ((loop_cnt_q + 8'd1) == n_loops_q);
  assign clst_sum  = {1'b0, clst_cnt_q} + {30'd0, vpf_cnt};

  // State register
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = sync_bx0 ? ST_WAIT : ST_READ;
      end
      ST_WAIT: begin
        if (stop)     state_d = ST_IDLE;
        else if (bx0) state_d = ST_READ;
      end
      ST_READ: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (at_last && last_pass) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // two cycles: read data stage, then output stage
        if (stop || drain_q) state_d = ST_IDLE;
        else                 drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    first_d     = first_q;
    last_d      = last_q;
    n_loops_d   = n_loops_q;
    ram_adr_d   = ram_adr_q;
    ram_rd_en_d = 1'b0;
    loop_cnt_d  = loop_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;
    frame_cnt_d = frame_cnt_q;
    clst_cnt_d  = clst_cnt_q;

    // Two-stage read pipeline; stop flushes both stages at once
    rdata_vld_d     = ram_rd_en_q && !kill;
    gemdata_valid_d = rdata_vld_q && !kill;
    gemdata_d       = gemdata_valid_d ? ram_rdata : IDLE_FRAME;

    if (gemdata_valid_d) begin
      if (frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_d = frame_cnt_q + 32'd1;
      clst_cnt_d = clst_sum[32] ? 32'hFFFF_FFFF : clst_sum[31:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (first_adr > last_adr) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d   = 1'b0;
            frame_cnt_d = 32'd0;
            clst_cnt_d  = 32'd0;
            loop_cnt_d  = 8'd0;
            first_d     = first_adr;
            last_d      = last_adr;
            n_loops_d   = n_loops;
            if (!sync_bx0) begin
              ram_rd_en_d = 1'b1;
              ram_adr_d   = first_adr;
            end
          end
        end
      end
      ST_WAIT: begin
        if (!stop && bx0) begin
          ram_rd_en_d = 1'b1;
          ram_adr_d   = first_q;
        end
      end
      ST_READ: begin
        if (!stop) begin
          if (at_last) begin
            loop_cnt_d = loop_cnt_q + 8'd1;
            if (!last_pass) begin
              ram_rd_en_d = 1'b1;
              ram_adr_d   = first_q;
            end
          end else begin
            ram_rd_en_d = 1'b1;
            ram_adr_d   = ram_adr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!stop && drain_q) done_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      first_q         <= '0;
      last_q          <= '0;
      n_loops_q       <= 8'd0;
      ram_adr_q       <= '0;
      ram_rd_en_q     <= 1'b0;
      rdata_vld_q     <= 1'b0;
      gemdata_valid_q <= 1'b0;
      gemdata_q       <= IDLE_FRAME;
      loop_cnt_q      <= 8'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
      frame_cnt_q     <= 32'd0;
      clst_cnt_q      <= 32'd0;
    end else begin
      first_q         <= first_d;
      last_q          <= last_d;
      n_loops_q       <= n_loops_d;
      ram_adr_q       <= ram_adr_d;
      ram_rd_en_q     <= ram_rd_en_d;
      rdata_vld_q     <= rdata_vld_d;
      gemdata_valid_q <= gemdata_valid_d;
      gemdata_q       <= gemdata_d;
      loop_cnt_q      <= loop_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cfg_err_q       <= cfg_err_d;
      frame_cnt_q     <= frame_cnt_d;
      clst_cnt_q      <= clst_cnt_d;
    end
  end

  assign ram_rd_en     = ram_rd_en_q;
  assign ram_adr       = ram_adr_q;
  assign gemdata       = gemdata_q;
  assign gemdata_valid = gemdata_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign loop_cnt      = loop_cnt_q;
  assign frame_cnt     = frame_cnt_q;
  assign clst_cnt      = clst_cnt_q;

endmodule

// File: tb/tb_gem_pattern_sequencer.sv
// tb/tb_gem_pattern_sequencer.sv - directed self-checking bench for gem_pattern_sequencer
module tb_gem_pattern_sequencer;

  localparam logic [55:0] IDLE_F = {4{14'h07FF}};

  logic        clock = 1'b0;
  logic        global_reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sync_bx0 = 1'b0, bx0 = 1'b0;
  logic [10:0] first_adr = '0, last_adr = '0;
  logic [7:0]  n_loops = '0;
  logic        ram_rd_en;
  logic [10:0] ram_adr;
  logic [55:0] ram_rdata = '0;
  logic [55:0] gemdata;
  logic        gemdata_valid, busy, done, cfg_err;
  logic [7:0]  loop_cnt;
  logic [31:0] frame_cnt, clst_cnt;

  logic [55:0] mem [0:2047];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (ram_rd_en) ram_rdata <= mem[ram_adr];

  gem_pattern_sequencer dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .start          (start),
    .stop           (stop),
    .sync_bx0       (sync_bx0),
    .bx0            (bx0),
    .first_adr      (first_adr),
    .last_adr       (last_adr),
    .n_loops        (n_loops),
    .ram_rd_en      (ram_rd_en),
    .ram_adr        (ram_adr),
    .ram_rdata      (ram_rdata),
    .gemdata        (gemdata),
    .gemdata_valid  (gemdata_valid),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .loop_cnt       (loop_cnt),
    .frame_cnt      (frame_cnt),
    .clst_cnt       (clst_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Pulses start for cycle 0; returns at the sample point of cycle 1
  task automatic start_play(input logic [10:0] f, input logic [10:0] l,
                            input logic [7:0] nl, input logic sy);
    @(negedge clock);
    first_adr = f; last_adr = l; n_loops = nl; sync_bx0 = sy; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++)
      mem[i] = {14'(i), 14'(i + 1), 14'(i + 2), 14'(i + 3)};
    mem[0] = {4{14'h07FF}};                                  // 0 valid
    mem[1] = {14'h07FF, 14'h07FF, 14'h07FF, 14'h0123};       // 1 valid
    mem[2] = {14'h0400, 14'h0200, 14'h3001, 14'h0000};       // 4 valid
    mem[3] = {14'h0E00, 14'h1005, 14'h0010, 14'h39FF};       // 3 valid

    // Reset values
    cyc(2);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_adr", ram_adr, 0);
    chk("rst_gemdata", gemdata, IDLE_F);
    chk("rst_valid", gemdata_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_loop_cnt", loop_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_clst_cnt", clst_cnt, 0);
    global_reset_n = 1'b1;

    // Idle for 100 cycles
    for (int c = 0; c < 100; c++) begin
      cyc(1);
      chk("idle_gemdata", gemdata, IDLE_F);
      chk("idle_valid", gemdata_valid, 0);
      chk("idle_busy", busy, 0);
    end

    // Window 5..8, two passes
    start_play(11'd5, 11'd8, 8'd2, 1'b0);
    chk("w58_rd_en_c1", ram_rd_en, 1);
    chk("w58_adr_c1", ram_adr, 5);
    chk("w58_busy_c1", busy, 1);
    cyc(1);
    chk("w58_valid_c2", gemdata_valid, 0);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      chk("w58_frame", gemdata, mem[5 + (k % 4)]);
      chk("w58_valid", gemdata_valid, 1);
      chk("w58_nodone", done, 0);
      cyc(1);
    end
    chk("w58_done", done, 1);
    chk("w58_valid_end", gemdata_valid, 0);
    chk("w58_gem_idle", gemdata, IDLE_F);
    chk("w58_loop_cnt", loop_cnt, 2);
    chk("w58_frame_cnt", frame_cnt, 8);
    chk("w58_clst_cnt", clst_cnt, 32);
    chk("w58_busy_end", busy, 0);
    cyc(1);
    chk("w58_done_once", done, 0);
    chk("w58_hold_frame_cnt", frame_cnt, 8);

    // Cluster counting, window 0..3, one pass
    start_play(11'd0, 11'd3, 8'd1, 1'b0);
    cyc(2);
    chk("clst_frame0", gemdata, mem[0]);
    chk("clst_valid0", gemdata_valid, 1);
    cyc(4);
    chk("clst_done", done, 1);
    chk("clst_frame_cnt", frame_cnt, 4);
    chk("clst_clst_cnt", clst_cnt, 8);
    chk("clst_loop_cnt", loop_cnt, 1);

    // bx0-aligned start, bx0 in cycle 20
    start_play(11'd10, 11'd12, 8'd1, 1'b1);
    chk("sync_busy", busy, 1);
    chk("sync_no_rd_c1", ram_rd_en, 0);
    cyc(19);
    chk("sync_no_rd_c20", ram_rd_en, 0);
    bx0 = 1'b1;
    cyc(1);
    bx0 = 1'b0;
    chk("sync_rd_c21", ram_rd_en, 1);
    chk("sync_adr_c21", ram_adr, 10);
    cyc(1);
    chk("sync_novalid_c22", gemdata_valid, 0);
    cyc(1);
    chk("sync_frame_c23", gemdata, mem[10]);
    chk("sync_valid_c23", gemdata_valid, 1);
    cyc(3);
    chk("sync_done_c26", done, 1);
    chk("sync_frame_cnt", frame_cnt, 3);

    // Endless single-frame loop, stop in cycle 50; start at 30 is ignored
    start_play(11'd0, 11'd0, 8'd0, 1'b0);
    cyc(2);
    for (int c = 3; c <= 50; c++) begin
      chk("loop_frame", gemdata, mem[0]);
      chk("loop_valid", gemdata_valid, 1);
      chk("loop_nodone", done, 0);
      if (c == 30) begin
        start = 1'b1; first_adr = 11'd7; last_adr = 11'd7;
      end else begin
        start = 1'b0;
      end
      stop = (c == 50);
      cyc(1);
    end
    stop = 1'b0;
    chk("stop_rd_en", ram_rd_en, 0);
    chk("stop_valid", gemdata_valid, 0);
    chk("stop_gem_idle", gemdata, IDLE_F);
    chk("stop_busy", busy, 0);
    for (int c = 0; c < 10; c++) begin
      chk("stop_nodone", done, 0);
      chk("stop_valid_hold", gemdata_valid, 0);
      cyc(1);
    end
    chk("stop_frame_cnt", frame_cnt, 48);
    chk("stop_clst_cnt", clst_cnt, 0);

    // Reversed window
    @(negedge clock);
    first_adr = 11'd10; last_adr = 11'd9; n_loops = 8'd1; sync_bx0 = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_rd_en", ram_rd_en, 0);
    chk("cfg_err_hold_cnt", frame_cnt, 48);

    // start and stop together in IDLE: nothing starts
    first_adr = 11'd5; last_adr = 11'd8; start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_rd_en", ram_rd_en, 0);
    chk("ss_cfg_err", cfg_err, 1);

    // Counter saturation on a 4-valid-cluster frame
    start_play(11'd2, 11'd2, 8'd0, 1'b0);
    chk("sat_cfg_err_clr", cfg_err, 0);
    cyc(4);
    force dut.frame_cnt_q = 32'hFFFF_FFFD;
    force dut.clst_cnt_q  = 32'hFFFF_FFF6;
    cyc(1);
    release dut.frame_cnt_q;
    release dut.clst_cnt_q;
    cyc(4);
    chk("sat_frame_cnt", frame_cnt, 32'hFFFF_FFFF);
    chk("sat_clst_cnt", clst_cnt, 32'hFFFF_FFFF);
    cyc(2);
    chk("sat_frame_hold", frame_cnt, 32'hFFFF_FFFF);
    chk("sat_clst_hold", clst_cnt, 32'hFFFF_FFFF);
    chk("sat_frame", gemdata, mem[2]);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("sat_stop_busy", busy, 0);

    // Asynchronous reset mid-playback
    start_play(11'd5, 11'd8, 8'd0, 1'b0);
    cyc(3);
    chk("ar_pre_valid", gemdata_valid, 1);
    #2 global_reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_valid", gemdata_valid, 0);
    chk("ar_gem_idle", gemdata, IDLE_F);
    chk("ar_rd_en", ram_rd_en, 0);
    chk("ar_frame_cnt", frame_cnt, 0);
    chk("ar_loop_cnt", loop_cnt, 0);
    @(negedge clock);
    global_reset_n = 1'b1;
    cyc(2);
    chk("ar_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
